// File: rtl/flow_frame_gen_pkg.sv
// Shared types, constants and frame-building helpers for the flow frame generator.
package flow_frame_gen_pkg;

  localparam int ETH_HDR_LEN     = 14;
  localparam int BEAT_BYTES      = 8;
  localparam int MIN_LEN_DEFAULT = 60;
  localparam int MAX_LEN_DEFAULT = 1514;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_SEND   = 2'd2
  } state_e;

  // One header table entry, 120 bits.
  typedef struct packed {
    logic [47:0] d_mac;
    logic [47:0] s_mac;
    logic [15:0] ethertype;
    logic [7:0]  payload;
  } flow_entry_t;

  // Bound a requested length into the legal frame size window.
  function automatic logic [10:0] clamp_len(input logic [10:0] len,
                                            input int min_len,
                                            input int max_len);
    if (int'(len) < min_len) begin
      clamp_len = 11'(min_len);
    end else if (int'(len) > max_len) begin
      clamp_len = 11'(max_len);
    end else begin
      clamp_len = len;
    end
  endfunction

  // Byte idx of the frame: header in network order, then the fill byte.
  function automatic logic [7:0] frame_byte(input flow_entry_t e, input logic [10:0] idx);
    logic [111:0] hdr;
    hdr = {e.d_mac, e.s_mac, e.ethertype};
    if (idx < 11'(ETH_HDR_LEN)) begin
      hdr        = hdr << {idx[3:0], 3'b000};
      frame_byte = hdr[111:104];
    end else begin
      frame_byte = e.payload;
    end
  endfunction

  // Lane data for one beat; lanes past the end of the frame are zero.
  function automatic logic [63:0] beat_data(input flow_entry_t e,
                                            input logic [7:0] beat,
                                            input logic [10:0] len);
    logic [10:0] idx;
    beat_data = '0;
    for (int i = 0; i < BEAT_BYTES; i++) begin
      idx = {beat, 3'(i)};
      if (idx < len) begin
        beat_data[8*i +: 8] = frame_byte(e, idx);
      end
    end
  endfunction

  // Byte enables for one beat: set for every lane that still holds frame bytes.
  function automatic logic [7:0] beat_keep(input logic [7:0] beat, input logic [10:0] len);
    logic [10:0] idx;
    beat_keep = '0;
    for (int i = 0; i < BEAT_BYTES; i++) begin
      idx = {beat, 3'(i)};
      if (idx < len) begin
        beat_keep[i] = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/flow_frame_gen_cfg_ram.sv
// Header table storage: one write port from configuration, one registered read port.
module flow_cfg_ram
  import flow_frame_gen_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  flow_entry_t       wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output flow_entry_t       rd_data_o
);

  flow_entry_t mem_q [DEPTH];
  flow_entry_t rd_data_q;

  // Store configuration writes; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read that returns the incoming write data when both ports hit one entry.
  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
        rd_data_q <= wr_data_i;
      end else begin
        rd_data_q <= mem_q[rd_addr_i];
      end
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/flow_frame_gen.sv
// Per-flow Ethernet frame generator: header table plus a 64-bit AXI-Stream frame builder.
module flow_frame_gen
  import flow_frame_gen_pkg::*;
#(
  parameter  int N_FLOWS    = 256,
  parameter  int MIN_LEN    = MIN_LEN_DEFAULT,
  parameter  int MAX_LEN    = MAX_LEN_DEFAULT,
  localparam int FLOW_WIDTH = (N_FLOWS > 1) ? $clog2(N_FLOWS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_en,
  input  logic [FLOW_WIDTH-1:0] cfg_id,
  input  logic [47:0]           cfg_d_mac,
  input  logic [47:0]           cfg_s_mac,
  input  logic [15:0]           cfg_ethertype,
  input  logic [7:0]            cfg_payload,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [FLOW_WIDTH-1:0] req_id,
  input  logic [10:0]           req_len,
  output logic                  req_err,
  output logic [63:0]           m_axis_tdata,
  output logic [7:0]            m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic [31:0]           frames_sent
);

  state_e         state_q;
  logic [N_FLOWS-1:0] valid_q;
  flow_entry_t    ram_rd_data;
  flow_entry_t    cfg_entry;
  flow_entry_t    entry_q;
  flow_entry_t    src_entry;
  logic [10:0]    len_q;
  logic [10:0]    len_clamped;
  logic [7:0]     last_beat_q;
  logic [7:0]     beat_q;
  logic [7:0]     beat_d;
  logic [63:0]    data_d;
  logic [7:0]     keep_d;
  logic           last_d;
  logic           hit_q;
  logic           lookup_hit;
  logic           accept;
  logic           req_ready_q;
  logic           req_err_q;
  logic [63:0]    tdata_q;
  logic [7:0]     tkeep_q;
  logic           tvalid_q;
  logic           tlast_q;
  logic [31:0]    frames_q;

  assign cfg_entry   = '{d_mac: cfg_d_mac, s_mac: cfg_s_mac,
                         ethertype: cfg_ethertype, payload: cfg_payload};
  assign accept      = req_valid && req_ready_q;
  assign len_clamped = clamp_len(req_len, MIN_LEN, MAX_LEN);
  // A configuration write landing in the accept cycle counts as configured.
  assign lookup_hit  = valid_q[req_id] | (cfg_en & (cfg_id == req_id));

  flow_cfg_ram #(
    .DEPTH (N_FLOWS),
    .ADDR_W(FLOW_WIDTH)
  ) u_ram (
    .clk      (clk),
    .wr_en_i  (cfg_en),
    .wr_addr_i(cfg_id),
    .wr_data_i(cfg_entry),
    .rd_en_i  (accept),
    .rd_addr_i(req_id),
    .rd_data_o(ram_rd_data)
  );

  // Track which flows have been configured since the last reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (cfg_en) begin
      valid_q[cfg_id] <= 1'b1;
    end
  end

  // Build the next beat: beat 0 from the fresh RAM read, later beats from the latched entry.
  always_comb begin
    src_entry = entry_q;
    beat_d    = beat_q + 8'd1;
    if (state_q == ST_LOOKUP) begin
      src_entry = ram_rd_data;
      beat_d    = '0;
    end
    data_d = beat_data(src_entry, beat_d, len_q);
    keep_d = beat_keep(beat_d, len_q);
    last_d = (beat_d == last_beat_q);
  end

  // Request/lookup/send sequencing with all stream outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      req_err_q   <= 1'b0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tkeep_q     <= '0;
      tdata_q     <= '0;
      frames_q    <= '0;
      beat_q      <= '0;
      len_q       <= '0;
      last_beat_q <= '0;
      hit_q       <= 1'b0;
      entry_q     <= '0;
    end else begin
      req_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q     <= ST_LOOKUP;
            req_ready_q <= 1'b0;
            len_q       <= len_clamped;
            last_beat_q <= 8'((len_clamped - 11'd1) >> 3);
            hit_q       <= lookup_hit;
            req_err_q   <= ~lookup_hit;
          end
        end
        ST_LOOKUP: begin
          entry_q <= ram_rd_data;
          if (!hit_q) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
          end else begin
            state_q  <= ST_SEND;
            beat_q   <= beat_d;
            tvalid_q <= 1'b1;
            tdata_q  <= data_d;
            tkeep_q  <= keep_d;
            tlast_q  <= last_d;
          end
        end
        ST_SEND: begin
          if (tvalid_q && m_axis_tready) begin
            if (tlast_q) begin
              state_q     <= ST_IDLE;
              req_ready_q <= 1'b1;
              tvalid_q    <= 1'b0;
              tlast_q     <= 1'b0;
              tkeep_q     <= '0;
              tdata_q     <= '0;
              frames_q    <= frames_q + 32'd1;
            end else begin
              beat_q  <= beat_d;
              tdata_q <= data_d;
              tkeep_q <= keep_d;
              tlast_q <= last_d;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          tvalid_q    <= 1'b0;
          tlast_q     <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign req_err       = req_err_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign frames_sent   = frames_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_flow_frame_gen.sv
// Self-checking bench for flow_frame_gen: hand-derived vector table, corner sequences, random frames.
module tb_flow_frame_gen;

  localparam int NF = 256;
  localparam int NV = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_en;
  logic [7:0]  cfg_id;
  logic [47:0] cfg_d_mac;
  logic [47:0] cfg_s_mac;
  logic [15:0] cfg_ethertype;
  logic [7:0]  cfg_payload;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_id;
  logic [10:0] req_len;
  logic        req_err;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        busy;
  logic [31:0] frames_sent;

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  flow_frame_gen #(.N_FLOWS(NF)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_en       (cfg_en),
    .cfg_id       (cfg_id),
    .cfg_d_mac    (cfg_d_mac),
    .cfg_s_mac    (cfg_s_mac),
    .cfg_ethertype(cfg_ethertype),
    .cfg_payload  (cfg_payload),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_id       (req_id),
    .req_len      (req_len),
    .req_err      (req_err),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .busy         (busy),
    .frames_sent  (frames_sent)
  );

  int cmpCount  = 0;
  int failCount = 0;

  // Reference model of the header table and the completed-frame counter.
  logic [47:0] mDmac [NF];
  logic [47:0] mSmac [NF];
  logic [15:0] mEt   [NF];
  logic [7:0]  mPl   [NF];
  bit          mValid[NF];
  logic [31:0] mFrames;

  typedef struct {
    int          reqLen;
    int          stallPct;
    int          expBeats;
    logic [7:0]  expLastKeep;
    logic [63:0] expBeat0;
    logic [63:0] expBeat1;
  } vec_t;

  vec_t vecs[NV];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmpCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int clampLen(input int len);
    int l;
    l = len;
    if (l > 1514) l = 1514;
    if (l < 60) l = 60;
    return l;
  endfunction

  task automatic cfgWrite(input int id, input logic [47:0] d, input logic [47:0] s,
                          input logic [15:0] et, input logic [7:0] pl);
    cfg_en        = 1'b1;
    cfg_id        = 8'(id);
    cfg_d_mac     = d;
    cfg_s_mac     = s;
    cfg_ethertype = et;
    cfg_payload   = pl;
    mDmac[id]  = d;
    mSmac[id]  = s;
    mEt[id]    = et;
    mPl[id]    = pl;
    mValid[id] = 1'b1;
    @(negedge clk);
    cfg_en = 1'b0;
  endtask

  // Issue one request and follow the resulting frame, checking every beat against the model.
  task automatic applyStimulus(input int id, input int len, input int stallPct,
                               input int cfgAtBeat, input logic [7:0] cfgPl,
                               input bit sameCycleCfg, input int rstAtBeat,
                               output int beats, output logic [7:0] lastKeep,
                               output logic [63:0] beat0, output logic [63:0] beat1);
    int          L, nBeats, beat, guard, idx;
    bit          expErr, done, cfgDone, sampledLast, sentReady;
    logic [7:0]  bytesQ[$];
    logic [63:0] expData;
    logic [7:0]  expKeep;
    logic        expLast;
    beats    = 0;
    lastKeep = '0;
    beat0    = '0;
    beat1    = '0;
    if (sameCycleCfg) begin
      cfg_en        = 1'b1;
      cfg_id        = 8'(id);
      cfg_d_mac     = mDmac[id];
      cfg_s_mac     = mSmac[id];
      cfg_ethertype = mEt[id];
      cfg_payload   = cfgPl;
      mPl[id]       = cfgPl;
      mValid[id]    = 1'b1;
    end
    expErr = !mValid[id];
    L      = clampLen(len);
    nBeats = (L + 7) / 8;
    bytesQ = {};
    for (int i = 5; i >= 0; i--) bytesQ.push_back(mDmac[id][8*i +: 8]);
    for (int i = 5; i >= 0; i--) bytesQ.push_back(mSmac[id][8*i +: 8]);
    bytesQ.push_back(mEt[id][15:8]);
    bytesQ.push_back(mEt[id][7:0]);
    for (int i = 14; i < L; i++) bytesQ.push_back(mPl[id]);

    req_valid = 1'b1;
    req_id    = 8'(id);
    req_len   = 11'(len);
    checkOutput("reqReadyIdle", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    cfg_en    = 1'b0;
    checkOutput("reqErrLookup", req_err, expErr);
    checkOutput("tvalidLookup", m_axis_tvalid, 0);
    checkOutput("busyLookup", busy, 1);
    checkOutput("reqReadyBusy", req_ready, 0);
    if (expErr) begin
      @(negedge clk);
      checkOutput("reqErrOneCycle", req_err, 0);
      checkOutput("reqReadyAfterErr", req_ready, 1);
      checkOutput("tvalidAfterErr", m_axis_tvalid, 0);
      checkOutput("framesAfterErr", frames_sent, mFrames);
      return;
    end
    @(negedge clk);
    checkOutput("firstBeatLatency", m_axis_tvalid, 1);

    beat    = 0;
    guard   = 0;
    done    = 1'b0;
    cfgDone = 1'b0;
    while (!done) begin
      cfg_en = 1'b0;
      guard++;
      if (rstAtBeat == beat) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("tvalidAfterRst", m_axis_tvalid, 0);
        checkOutput("tlastAfterRst", m_axis_tlast, 0);
        checkOutput("busyAfterRst", busy, 0);
        checkOutput("reqReadyAfterRst", req_ready, 1);
        checkOutput("framesAfterRst", frames_sent, 0);
        mFrames = '0;
        for (int i = 0; i < NF; i++) mValid[i] = 1'b0;
        beats = beat;
        return;
      end
      if (!m_axis_tvalid || guard > 5000 || beat > nBeats) begin
        checkOutput("tvalidHeldInFrame", {m_axis_tvalid, 31'(beat)}, {1'b1, 31'(nBeats)});
        done = 1'b1;
      end else begin
        expData = '0;
        expKeep = '0;
        for (int i = 0; i < 8; i++) begin
          idx = beat * 8 + i;
          if (idx < L) begin
            expData[8*i +: 8] = bytesQ[idx];
            expKeep[i]        = 1'b1;
          end
        end
        expLast = (beat == nBeats - 1);
        checkOutput("tdata", m_axis_tdata, expData);
        checkOutput("tkeep", m_axis_tkeep, expKeep);
        checkOutput("tlast", m_axis_tlast, expLast);
        if (beat == 0) beat0 = m_axis_tdata;
        if (beat == 1) beat1 = m_axis_tdata;
        sampledLast   = m_axis_tlast;
        if (sampledLast) lastKeep = m_axis_tkeep;
        sentReady     = ($urandom_range(99) >= stallPct);
        m_axis_tready = sentReady;
        if (cfgAtBeat == beat && !cfgDone) begin
          cfg_en        = 1'b1;
          cfg_id        = 8'(id);
          cfg_d_mac     = mDmac[id];
          cfg_s_mac     = mSmac[id];
          cfg_ethertype = mEt[id];
          cfg_payload   = cfgPl;
          mPl[id]       = cfgPl;
          cfgDone       = 1'b1;
        end
        @(negedge clk);
        if (sentReady) begin
          beat++;
          if (sampledLast) done = 1'b1;
        end
      end
    end
    cfg_en = 1'b0;
    beats  = beat;
    if (sampledLast) mFrames = mFrames + 32'd1;
    checkOutput("tvalidAfterFrame", m_axis_tvalid, 0);
    checkOutput("busyAfterFrame", busy, 0);
    checkOutput("reqReadyAfterFrame", req_ready, 1);
    checkOutput("framesSent", frames_sent, mFrames);
  endtask

  initial begin
    int          beats, id, len;
    logic [7:0]  lastKeep;
    logic [63:0] beat0, beat1;

    vecs[0] = '{64,   0,  8,   8'hFF, 64'h0002_0100_0000_0002, 64'hA5A5_B588_0200_0000};
    vecs[1] = '{10,   0,  8,   8'h0F, 64'h0002_0100_0000_0002, 64'hA5A5_B588_0200_0000};
    vecs[2] = '{2000, 0,  190, 8'h03, 64'h0002_0100_0000_0002, 64'hA5A5_B588_0200_0000};
    vecs[3] = '{100,  40, 13,  8'h0F, 64'h0002_0100_0000_0002, 64'hA5A5_B588_0200_0000};
    vecs[4] = '{60,   0,  8,   8'h0F, 64'h0002_0100_0000_0002, 64'hA5A5_B588_0200_0000};
    vecs[5] = '{1514, 20, 190, 8'h03, 64'h0002_0100_0000_0002, 64'hA5A5_B588_0200_0000};
    vecs[6] = '{61,   0,  8,   8'h1F, 64'h0002_0100_0000_0002, 64'hA5A5_B588_0200_0000};
    vecs[7] = '{65,   30, 9,   8'h01, 64'h0002_0100_0000_0002, 64'hA5A5_B588_0200_0000};

    for (int i = 0; i < NF; i++) begin
      mDmac[i]  = '0;
      mSmac[i]  = '0;
      mEt[i]    = '0;
      mPl[i]    = '0;
      mValid[i] = 1'b0;
    end
    mFrames       = '0;
    rst           = 1'b1;
    cfg_en        = 1'b0;
    cfg_id        = '0;
    cfg_d_mac     = '0;
    cfg_s_mac     = '0;
    cfg_ethertype = '0;
    cfg_payload   = '0;
    req_valid     = 1'b0;
    req_id        = '0;
    req_len       = '0;
    m_axis_tready = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("rstReqReady", req_ready, 1);
    checkOutput("rstReqErr", req_err, 0);
    checkOutput("rstTvalid", m_axis_tvalid, 0);
    checkOutput("rstTlast", m_axis_tlast, 0);
    checkOutput("rstTkeep", m_axis_tkeep, 0);
    checkOutput("rstTdata", m_axis_tdata, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstFrames", frames_sent, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] unconfigured flow request");
    applyStimulus(7, 64, 0, -1, 8'h00, 1'b0, -1, beats, lastKeep, beat0, beat1);

    $display("[TB] vector table on flow 3");
    cfgWrite(3, 48'h02_00_00_00_00_01, 48'h02_00_00_00_00_02, 16'h88B5, 8'hA5);
    for (int v = 0; v < NV; v++) begin
      applyStimulus(3, vecs[v].reqLen, vecs[v].stallPct, -1, 8'h00, 1'b0, -1,
                    beats, lastKeep, beat0, beat1);
      checkOutput($sformatf("vec%0dBeats", v), 64'(beats), 64'(vecs[v].expBeats));
      checkOutput($sformatf("vec%0dLastKeep", v), lastKeep, vecs[v].expLastKeep);
      checkOutput($sformatf("vec%0dBeat0", v), beat0, vecs[v].expBeat0);
      checkOutput($sformatf("vec%0dBeat1", v), beat1, vecs[v].expBeat1);
    end

    $display("[TB] payload rewrite during send");
    applyStimulus(3, 64, 0, 3, 8'h5A, 1'b0, -1, beats, lastKeep, beat0, beat1);
    checkOutput("inFlightPayload", beat1[63:56], 8'hA5);
    applyStimulus(3, 64, 0, -1, 8'h00, 1'b0, -1, beats, lastKeep, beat0, beat1);
    checkOutput("rewrittenPayload", beat1[63:56], 8'h5A);
    cfgWrite(3, 48'h02_00_00_00_00_01, 48'h02_00_00_00_00_02, 16'h88B5, 8'hA5);
    applyStimulus(3, 64, 0, -1, 8'h5A, 1'b1, -1, beats, lastKeep, beat0, beat1);
    checkOutput("sameCycleCfgPayload", beat1[63:56], 8'h5A);

    $display("[TB] reset mid-frame");
    applyStimulus(3, 200, 0, -1, 8'h00, 1'b0, 4, beats, lastKeep, beat0, beat1);
    @(negedge clk);
    applyStimulus(3, 64, 0, -1, 8'h00, 1'b0, -1, beats, lastKeep, beat0, beat1);

    $display("[TB] randomized frames");
    for (int r = 0; r < 24; r++) begin
      id = int'($urandom_range(15));
      if ($urandom_range(2) == 0) begin
        cfgWrite(id, 48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}),
                 16'($urandom()), 8'($urandom()));
      end
      if ($urandom_range(3) == 0) len = int'($urandom_range(2047));
      else len = int'($urandom_range(200));
      applyStimulus(id, len, int'($urandom_range(60)),
                    ($urandom_range(3) == 0) ? int'($urandom_range(5)) : -1,
                    8'($urandom()), ($urandom_range(5) == 0), -1,
                    beats, lastKeep, beat0, beat1);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", cmpCount, failCount);
    $finish;
  end

endmodule

// File: doc/flow_frame_gen.md
Name: flow_frame_gen

Overview:
- Consumer end of the manager configuration interface (cfg_en / cfg_id / header fields).
- Holds a per-flow header table of N_FLOWS entries, written by cfg_en pulses.
- On a transmit request for a flow ID, builds one Ethernet frame from that flow's entry. The frame carries the destination MAC, source MAC, ethertype and a repeated payload byte.
- Emits the frame on a 64-bit AXI-Stream master toward the MAC TX path.

Parameters:
- N_FLOWS, 256, number of flow entries.
- FLOW_WIDTH, derived: $clog2(N_FLOWS) when N_FLOWS>1, otherwise 1. Not overridable.
- MIN_LEN, 60, minimum frame length in bytes (excludes FCS).
- MAX_LEN, 1514, maximum frame length in bytes (excludes FCS).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cfg_en  in  1  single-cycle pulse: write the header fields into entry cfg_id.
- cfg_id  in  FLOW_WIDTH  flow entry to write.
- cfg_d_mac  in  48  destination MAC.
- cfg_s_mac  in  48  source MAC.
- cfg_ethertype  in  16  ethertype.
- cfg_payload  in  8  payload fill byte.
- req_valid  in  1  transmit request.
- req_ready  out  1  request accepted while req_valid and req_ready are both high.
- req_id  in  FLOW_WIDTH  flow ID to transmit.
- req_len  in  11  frame length in bytes.
- req_err  out  1  one-cycle pulse: accepted request was for an unconfigured flow.
- m_axis_tdata  out  64  frame data; byte n of the beat is on lane n, tdata[7:0] = lowest byte.
- m_axis_tkeep  out  8  byte enables.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  last beat of frame.
- busy  out  1  a frame is being looked up or sent.
- frames_sent  out  32  count of completed frames; wraps at 2^32.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - All per-flow valid bits clear.
  - req_ready=1, req_err=0, m_axis_tvalid=0, m_axis_tlast=0, tkeep=0, tdata=0, busy=0, frames_sent=0.
  - Table RAM contents are not reset.
- Table writes:
  - cfg_en writes all four fields into entry cfg_id and sets valid[cfg_id]. This happens in every state.
  - A write never alters a frame already in flight; header fields are latched at LOOKUP.
- Request handshake:
  - Accept occurs when req_valid && req_ready.
  - req_ready is high only in IDLE.
  - On accept, latch req_id and the clamped length: L = max(MIN_LEN, min(MAX_LEN, req_len)).
- State machine, IDLE -> LOOKUP -> SEND -> IDLE:
  - IDLE: on accept, go to LOOKUP and issue the RAM read.
  - LOOKUP (one cycle): latch the entry.
    - If the valid bit is clear: pulse req_err and return to IDLE; no beats are emitted.
    - Otherwise go to SEND.
  - SEND: a beat counter advances when tvalid && tready.
    - Total beats = ceil(L/8).
    - On the final beat, tlast=1 and tkeep = (L%8==0) ? 8'hFF : (1<<(L%8))-1. All other beats have tkeep=8'hFF.
    - When the final beat transfers: frames_sent increments and the state returns to IDLE.
    - A new request can be accepted the following cycle.
- Latency: accept in cycle T; first beat valid in cycle T+2.
- Frame byte order, network order, most-significant byte first:
  - Bytes 0–5: d_mac[47:40] .. d_mac[7:0].
  - Bytes 6–11: s_mac[47:40] .. s_mac[7:0].
  - Bytes 12–13: ethertype[15:8], ethertype[7:0].
  - Bytes 14..L-1: payload byte.
- AXI-Stream rules:
  - Once tvalid is asserted, tdata/tkeep/tlast stay stable until tready.
  - tvalid never drops mid-frame; there are no gaps the source inserts.
  - Lanes outside tkeep are driven 0.
- Simultaneous events:
  - cfg_en and accept in the same cycle for the same ID: LOOKUP reads the new data. The RAM is write-first, or the write data is forwarded at LOOKUP.
  - cfg_en to the in-flight ID during SEND has no effect on the current frame.
- Reset mid-frame: the frame is abandoned immediately and tvalid is 0 in the next cycle. No tlast is emitted.
- busy = (state != IDLE).

Decomposition:
- Shared package contents:
  - Ethernet header length constant: 14.
  - Beat width: 8 bytes.
  - MIN_LEN and MAX_LEN defaults.
  - State encoding: IDLE, LOOKUP, SEND.
  - The flow-entry struct: d_mac, s_mac, ethertype, payload; 120 bits.
- Sub-module flow_cfg_ram:
  - Simple dual-port RAM, N_FLOWS x 120 bits.
  - One write port (cfg side) and one registered read port.
  - Write-first on an address collision.
- The valid-bit vector stays in the top level so that it can be reset.

Test Plan:
1. Configure flow 3: d_mac=02:00:00:00:00:01, s_mac=02:00:00:00:00:02, ethertype=0x88B5, payload=0xA5. Request id=3, len=64, tready=1.
   -> 8 beats; beat0 bytes = 02 00 00 00 00 01 02 00; beat1 = 00 00 00 02 88 B5 A5 A5; beats 2–7 = all A5; tlast on beat 7 with tkeep=FF; frames_sent=1.
2. Same flow, len=10 and len=2000.
   -> Clamped to 60 (8 beats, last tkeep=0x0F) and 1514 (190 beats, last tkeep=0x03).
3. Request id=7 after reset with no configuration.
   -> req_err pulses in cycle T+1, no tvalid, req_ready high again at T+2, frames_sent unchanged.
4. Random tready backpressure during a 100-byte frame.
   -> Data/tkeep/tlast held stable while stalled; 13 beats total; last tkeep=0x0F.
5. cfg_en rewrites flow 3 payload to 0x5A during SEND, then a second request for flow 3.
   -> First frame payload stays A5; second frame payload is 5A. Same-cycle cfg_en plus accept yields 5A.
6. Assert rst during beat 4 of a frame.
   -> tvalid=0 on the next cycle; all valid bits cleared; a following request for flow 3 returns req_err.
